// File: rtl/car_link_responder.sv
// car_link_responder: far end of the car UART link (8N1, LSB first).
// Receives command frames {hdr[1:0], destroy, place, right, left, back, fwd},
// validates header and stop bit, and decodes them into registered drive
// outputs. Every accepted frame is answered with one status byte
// {4'b0, back, right, left, front} on txd. RX and TX run concurrently.
// Optional feature macro: LINK_WATCHDOG_EN (link-loss watchdog that clears the
// drive outputs after WDT_CYCLES without an accepted frame).
//
// RX state | meaning
// ---------+--------------------------------------------------------------
// RX_IDLE  | line idle, waiting for a low level on synchronised rxd
// RX_START | timing to mid start bit, rejects short glitches
// RX_DATA  | sampling 8 data bits at mid-bit, LSB first
// RX_STOP  | sampling the stop bit, issuing accept / frame_err / hdr_err
// RX_BREAK | stop bit was low, waiting for the line to return high
//
// TX state | meaning
// ---------+--------------------------------------------------------------
// TX_IDLE  | txd high; launches a reply when one is pending
// TX_START | driving start bit
// TX_DATA  | shifting out 8 status bits, LSB first
// TX_STOP  | driving stop bit
module car_link_responder #(
    parameter int         CLKS_PER_BIT = 10416,
    parameter logic [1:0] HDR          = 2'b10,
    parameter int         WDT_CYCLES   = 100_000_000
) (
    input  logic sys_clk,
    input  logic rst,
    input  logic rxd,
    output logic txd,
    input  logic front_det,
    input  logic left_det,
    input  logic right_det,
    input  logic back_det,
    output logic move_fwd,
    output logic move_back,
    output logic turn_left,
    output logic turn_right,
    output logic place_barrier,
    output logic destroy_barrier,
    output logic cmd_valid,
    output logic frame_err,
    output logic hdr_err,
    output logic link_lost
);

    localparam int            CW      = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_BREAK} rx_state_t;
    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;

    logic          rx_meta, rx_sync;
    rx_state_t     rx_st, rx_nxt;
    logic [CW-1:0] rx_cnt, rx_cnt_nxt;
    logic [2:0]    rx_bit, rx_bit_nxt;
    logic [7:0]    rx_data, rx_data_nxt;
    logic          accept, frame_bad, hdr_bad;

    tx_state_t     tx_st, tx_nxt;
    logic [CW-1:0] tx_cnt, tx_cnt_nxt;
    logic [2:0]    tx_bit, tx_bit_nxt;
    logic [7:0]    tx_sh, tx_sh_nxt;
    logic          txd_nxt;
    logic          tx_load;
    logic          pending;
    logic          wdt_expire;

    // Two-flop synchroniser for the asynchronous serial input (idles high).
    always_ff @(posedge sys_clk or negedge rst) begin
        if (!rst) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
        end else begin
            rx_meta <= rxd;
            rx_sync <= rx_meta;
        end
    end

    // RX state, bit timer, bit index and shift register.
    always_ff @(posedge sys_clk or negedge rst) begin
        if (!rst) begin
            rx_st   <= RX_IDLE;
            rx_cnt  <= '0;
            rx_bit  <= '0;
            rx_data <= '0;
        end else begin
            rx_st   <= rx_nxt;
            rx_cnt  <= rx_cnt_nxt;
            rx_bit  <= rx_bit_nxt;
            rx_data <= rx_data_nxt;
        end
    end

    // RX next-state: down-counter reaching zero marks each mid-bit sample point.
    always_comb begin
        rx_nxt      = rx_st;
        rx_cnt_nxt  = (rx_cnt == '0) ? '0 : rx_cnt - CW'(1);
        rx_bit_nxt  = rx_bit;
        rx_data_nxt = rx_data;
        accept      = 1'b0;
        frame_bad   = 1'b0;
        hdr_bad     = 1'b0;
        case (rx_st)
            RX_IDLE: begin
                rx_cnt_nxt = '0;
                if (!rx_sync) begin
                    rx_nxt     = RX_START;
                    rx_cnt_nxt = HALF_M1;
                    rx_bit_nxt = '0;
                end
            end
            RX_START: begin
                if (rx_cnt == '0) begin
                    if (rx_sync) begin
                        rx_nxt = RX_IDLE;
                    end else begin
                        rx_nxt     = RX_DATA;
                        rx_cnt_nxt = FULL_M1;
                    end
                end
            end
            RX_DATA: begin
                if (rx_cnt == '0) begin
                    rx_data_nxt = {rx_sync, rx_data[7:1]};
                    rx_cnt_nxt  = FULL_M1;
                    rx_bit_nxt  = rx_bit + 3'd1;
                    if (rx_bit == 3'd7) begin
                        rx_nxt = RX_STOP;
                    end
                end
            end
            RX_STOP: begin
                if (rx_cnt == '0) begin
                    if (!rx_sync) begin
                        frame_bad = 1'b1;
                        rx_nxt    = RX_BREAK;
                    end else if (rx_data[7:6] != HDR) begin
                        hdr_bad = 1'b1;
                        rx_nxt  = RX_IDLE;
                    end else begin
                        accept = 1'b1;
                        rx_nxt = RX_IDLE;
                    end
                end
            end
            RX_BREAK: begin
                rx_cnt_nxt = '0;
                if (rx_sync) begin
                    rx_nxt = RX_IDLE;
                end
            end
            default: rx_nxt = RX_IDLE;
        endcase
    end

    // Status pulses, one cycle each, aligned with the drive-output update.
    always_ff @(posedge sys_clk or negedge rst) begin
        if (!rst) begin
            cmd_valid <= 1'b0;
            frame_err <= 1'b0;
            hdr_err   <= 1'b0;
        end else begin
            cmd_valid <= accept;
            frame_err <= frame_bad;
            hdr_err   <= hdr_bad;
        end
    end

    // Drive decode: contradictory pairs cancel to 0; the watchdog clears everything.
    always_ff @(posedge sys_clk or negedge rst) begin
        if (!rst) begin
            move_fwd        <= 1'b0;
            move_back       <= 1'b0;
            turn_left       <= 1'b0;
            turn_right      <= 1'b0;
            place_barrier   <= 1'b0;
            destroy_barrier <= 1'b0;
        end else if (accept) begin
            move_fwd        <= rx_data[0] & ~rx_data[1];
            move_back       <= rx_data[1] & ~rx_data[0];
            turn_left       <= rx_data[2] & ~rx_data[3];
            turn_right      <= rx_data[3] & ~rx_data[2];
            place_barrier   <= rx_data[4] & ~rx_data[5];
            destroy_barrier <= rx_data[5] & ~rx_data[4];
        end else if (wdt_expire) begin
            move_fwd        <= 1'b0;
            move_back       <= 1'b0;
            turn_left       <= 1'b0;
            turn_right      <= 1'b0;
            place_barrier   <= 1'b0;
            destroy_barrier <= 1'b0;
        end
    end

    // Reply request: accepts during a reply collapse into one extra reply.
    always_ff @(posedge sys_clk or negedge rst) begin
        if (!rst) begin
            pending <= 1'b0;
        end else if (accept) begin
            pending <= 1'b1;
        end else if (tx_load) begin
            pending <= 1'b0;
        end
    end

    // TX state, bit timer, shift register and registered txd.
    always_ff @(posedge sys_clk or negedge rst) begin
        if (!rst) begin
            tx_st  <= TX_IDLE;
            tx_cnt <= '0;
            tx_bit <= '0;
            tx_sh  <= '0;
            txd    <= 1'b1;
        end else begin
            tx_st  <= tx_nxt;
            tx_cnt <= tx_cnt_nxt;
            tx_bit <= tx_bit_nxt;
            tx_sh  <= tx_sh_nxt;
            txd    <= txd_nxt;
        end
    end

    // TX next-state: txd_nxt is the line level for the state being entered.
    always_comb begin
        tx_nxt     = tx_st;
        tx_cnt_nxt = (tx_cnt == '0) ? '0 : tx_cnt - CW'(1);
        tx_bit_nxt = tx_bit;
        tx_sh_nxt  = tx_sh;
        tx_load    = 1'b0;
        txd_nxt    = 1'b1;
        case (tx_st)
            TX_IDLE: begin
                if (pending) begin
                    tx_load    = 1'b1;
                    tx_nxt     = TX_START;
                    tx_cnt_nxt = FULL_M1;
                    tx_bit_nxt = '0;
                    tx_sh_nxt  = {4'b0000, back_det, right_det, left_det, front_det};
                    txd_nxt    = 1'b0;
                end
            end
            TX_START: begin
                txd_nxt = 1'b0;
                if (tx_cnt == '0) begin
                    tx_nxt     = TX_DATA;
                    tx_cnt_nxt = FULL_M1;
                    txd_nxt    = tx_sh[0];
                end
            end
            TX_DATA: begin
                txd_nxt = tx_sh[0];
                if (tx_cnt == '0) begin
                    tx_cnt_nxt = FULL_M1;
                    if (tx_bit == 3'd7) begin
                        tx_nxt  = TX_STOP;
                        txd_nxt = 1'b1;
                    end else begin
                        tx_sh_nxt  = {1'b0, tx_sh[7:1]};
                        tx_bit_nxt = tx_bit + 3'd1;
                        txd_nxt    = tx_sh[1];
                    end
                end
            end
            TX_STOP: begin
                if (tx_cnt == '0) begin
                    tx_nxt = TX_IDLE;
                end
            end
            default: tx_nxt = TX_IDLE;
        endcase
    end

`ifdef LINK_WATCHDOG_EN
    localparam int            WW      = $clog2(WDT_CYCLES + 1);
    localparam logic [WW-1:0] WDT_END = WW'(WDT_CYCLES);
    localparam logic [WW-1:0] WDT_M1  = WW'(WDT_CYCLES - 1);

    logic [WW-1:0] wdt_cnt;

    assign wdt_expire = !accept && (wdt_cnt == WDT_M1);

    // Watchdog: saturating count since the last accept; errors do not restart it.
    always_ff @(posedge sys_clk or negedge rst) begin
        if (!rst) begin
            wdt_cnt   <= '0;
            link_lost <= 1'b0;
        end else if (accept) begin
            wdt_cnt   <= '0;
            link_lost <= 1'b0;
        end else if (wdt_cnt != WDT_END) begin
            wdt_cnt <= wdt_cnt + WW'(1);
            if (wdt_cnt == WDT_M1) begin
                link_lost <= 1'b1;
            end
        end
    end
`else
    logic unused_wdt;

    assign unused_wdt = (WDT_CYCLES > 0);
    assign wdt_expire = 1'b0;
    assign link_lost  = 1'b0;
`endif

endmodule

// File: tb/tb_car_link_responder.sv
// Bench for car_link_responder with CLKS_PER_BIT=16, WDT_CYCLES=2000.
// A table of frames with hand-computed results, followed by hand-written
// sequences for glitch rejection, back-to-back replies, watchdog / hold
// behaviour and reset in mid-frame.
module tb_car_link_responder;

    localparam int CPB = 16;
    localparam int WDT = 2000;

    logic       sys_clk = 1'b0;
    logic       rst;
    logic       rxd;
    logic       txd;
    logic [3:0] det;
    logic       move_fwd, move_back, turn_left, turn_right;
    logic       place_barrier, destroy_barrier;
    logic       cmd_valid, frame_err, hdr_err, link_lost;
    logic [5:0] drive;

    int checks = 0;
    int errors = 0;

    int cyc = 0;
    int n_cv = 0, n_fe = 0, n_he = 0, n_txfall = 0;
    int cv_cyc = 0, tx_fall_cyc = 0;
    logic [7:0] replies[$];

    car_link_responder #(
        .CLKS_PER_BIT(CPB),
        .HDR         (2'b10),
        .WDT_CYCLES  (WDT)
    ) dut (
        .sys_clk        (sys_clk),
        .rst            (rst),
        .rxd            (rxd),
        .txd            (txd),
        .front_det      (det[0]),
        .left_det       (det[1]),
        .right_det      (det[2]),
        .back_det       (det[3]),
        .move_fwd       (move_fwd),
        .move_back      (move_back),
        .turn_left      (turn_left),
        .turn_right     (turn_right),
        .place_barrier  (place_barrier),
        .destroy_barrier(destroy_barrier),
        .cmd_valid      (cmd_valid),
        .frame_err      (frame_err),
        .hdr_err        (hdr_err),
        .link_lost      (link_lost)
    );

    assign drive = {destroy_barrier, place_barrier, turn_right, turn_left, move_back, move_fwd};

    always #5 sys_clk = ~sys_clk;

    always @(posedge sys_clk) cyc++;

    // Pulse counters, sampled on the falling edge.
    always @(negedge sys_clk) begin
        if (cmd_valid) begin
            n_cv++;
            cv_cyc = cyc;
        end
        if (frame_err) n_fe++;
        if (hdr_err)   n_he++;
    end

    // Independent UART receiver for the status replies.
    initial begin : reply_rx
        logic [7:0] b;
        forever begin
            @(negedge sys_clk);
            if (rst === 1'b1 && txd === 1'b0) begin
                n_txfall++;
                tx_fall_cyc = cyc;
                repeat (CPB / 2) @(negedge sys_clk);
                for (int i = 0; i < 8; i++) begin
                    repeat (CPB) @(negedge sys_clk);
                    b[i] = txd;
                end
                repeat (CPB) @(negedge sys_clk);
                replies.push_back(b);
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] data, input logic stop);
        @(negedge sys_clk);
        rxd = 1'b0;
        repeat (CPB) @(negedge sys_clk);
        for (int i = 0; i < 8; i++) begin
            rxd = data[i];
            repeat (CPB) @(negedge sys_clk);
        end
        rxd = stop;
        repeat (CPB) @(negedge sys_clk);
        rxd = 1'b1;
    endtask

    typedef struct {
        logic [7:0] frame;
        logic       stop;
        logic [3:0] det;
        int         cv;
        int         fe;
        int         he;
        logic [5:0] drive;
        int         nrep;
        logic [7:0] rep;
    } vec_t;

    vec_t vecs[10];

    initial begin : main
        int b_cv, b_fe, b_he, b_rep, b_fall;
        int waited;

        vecs[0] = '{8'h85, 1'b1, 4'b0011, 1, 0, 0, 6'b000101, 1, 8'h03};
        vecs[1] = '{8'h83, 1'b1, 4'b0101, 1, 0, 0, 6'b000000, 1, 8'h05};
        vecs[2] = '{8'hAA, 1'b1, 4'b1111, 1, 0, 0, 6'b101010, 1, 8'h0F};
        vecs[3] = '{8'h8C, 1'b1, 4'b1010, 1, 0, 0, 6'b000000, 1, 8'h0A};
        vecs[4] = '{8'h90, 1'b1, 4'b0110, 1, 0, 0, 6'b010000, 1, 8'h06};
        vecs[5] = '{8'hB0, 1'b1, 4'b1001, 1, 0, 0, 6'b000000, 1, 8'h09};
        vecs[6] = '{8'h95, 1'b1, 4'b0000, 1, 0, 0, 6'b010101, 1, 8'h00};
        vecs[7] = '{8'h41, 1'b1, 4'b1111, 0, 0, 1, 6'b010101, 0, 8'h00};
        vecs[8] = '{8'h81, 1'b0, 4'b1111, 0, 1, 0, 6'b010101, 0, 8'h00};
        vecs[9] = '{8'h88, 1'b1, 4'b0100, 1, 0, 0, 6'b001000, 1, 8'h04};

        rst = 1'b0;
        rxd = 1'b1;
        det = 4'b0000;
        repeat (3) @(negedge sys_clk);
        check("reset_txd", txd, 1);
        check("reset_drive", drive, 0);
        check("reset_pulses", {cmd_valid, frame_err, hdr_err, link_lost}, 0);
        rst = 1'b1;

        // Idle line after reset: nothing happens for 500 cycles.
        repeat (500) @(negedge sys_clk);
        check("idle_txd", txd, 1);
        check("idle_drive", drive, 0);
        check("idle_pulses", n_cv + n_fe + n_he, 0);
        check("idle_tx_activity", n_txfall, 0);
        check("idle_link_lost", link_lost, 0);

        for (int i = 0; i < 10; i++) begin
            det   = vecs[i].det;
            b_cv  = n_cv;
            b_fe  = n_fe;
            b_he  = n_he;
            b_rep = replies.size();
            send_byte(vecs[i].frame, vecs[i].stop);
            repeat (200) @(negedge sys_clk);
            check($sformatf("v%0d_cmd_valid", i), n_cv - b_cv, vecs[i].cv);
            check($sformatf("v%0d_frame_err", i), n_fe - b_fe, vecs[i].fe);
            check($sformatf("v%0d_hdr_err", i), n_he - b_he, vecs[i].he);
            check($sformatf("v%0d_drive", i), drive, vecs[i].drive);
            check($sformatf("v%0d_reply_count", i), replies.size() - b_rep, vecs[i].nrep);
            if (vecs[i].nrep == 1 && replies.size() > b_rep)
                check($sformatf("v%0d_reply_byte", i), replies[b_rep], vecs[i].rep);
            if (i == 0)
                check("v0_reply_latency_le2",
                      (tx_fall_cyc >= cv_cyc) && (tx_fall_cyc - cv_cyc <= 2), 1);
            check($sformatf("v%0d_txd_idle", i), txd, 1);
        end

        // 8-cycle low glitch must be ignored, then a real frame decodes.
        b_cv = n_cv; b_fe = n_fe; b_he = n_he; b_fall = n_txfall;
        @(negedge sys_clk);
        rxd = 1'b0;
        repeat (8) @(negedge sys_clk);
        rxd = 1'b1;
        repeat (40) @(negedge sys_clk);
        check("glitch_pulses", (n_cv - b_cv) + (n_fe - b_fe) + (n_he - b_he), 0);
        check("glitch_no_reply", n_txfall - b_fall, 0);
        check("glitch_drive_hold", drive, 6'b001000);
        det   = 4'b0001;
        b_cv  = n_cv;
        b_rep = replies.size();
        send_byte(8'h82, 1'b1);
        repeat (200) @(negedge sys_clk);
        check("post_glitch_cmd_valid", n_cv - b_cv, 1);
        check("post_glitch_drive", drive, 6'b000010);
        check("post_glitch_reply_count", replies.size() - b_rep, 1);
        if (replies.size() > b_rep)
            check("post_glitch_reply_byte", replies[b_rep], 8'h01);

        // Back-to-back frames: two replies, second one sees the new detectors.
        det   = 4'b0010;
        b_cv  = n_cv;
        b_rep = replies.size();
        send_byte(8'h81, 1'b1);
        det = 4'b1100;
        send_byte(8'h84, 1'b1);
        waited = 0;
        while (replies.size() < b_rep + 2 && waited < 800) begin
            @(negedge sys_clk);
            waited++;
        end
        check("b2b_wait_bound", waited < 800, 1);
        repeat (200) @(negedge sys_clk);
        check("b2b_cmd_valid", n_cv - b_cv, 2);
        check("b2b_reply_count", replies.size() - b_rep, 2);
        if (replies.size() >= b_rep + 2) begin
            check("b2b_reply0", replies[b_rep], 8'h02);
            check("b2b_reply1", replies[b_rep + 1], 8'h0C);
        end
        check("b2b_drive", drive, 6'b000100);

`ifdef LINK_WATCHDOG_EN
        check("wdt_not_yet", link_lost, 0);
        repeat (WDT + 100) @(negedge sys_clk);
        check("wdt_link_lost", link_lost, 1);
        check("wdt_drive_cleared", drive, 0);
        det = 4'b0000;
        send_byte(8'h84, 1'b1);
        repeat (20) @(negedge sys_clk);
        check("wdt_recover_link", link_lost, 0);
        check("wdt_recover_drive", drive, 6'b000100);
        repeat (200) @(negedge sys_clk);
`else
        repeat (WDT + 100) @(negedge sys_clk);
        check("hold_drive", drive, 6'b000100);
        check("hold_link_lost", link_lost, 0);
`endif

        // Reset in the middle of an incoming frame and an outgoing reply.
        det = 4'b0011;
        send_byte(8'h85, 1'b1);
        @(negedge sys_clk);
        rxd = 1'b0;
        repeat (49) @(negedge sys_clk);
        check("pre_reset_txd_low", txd, 0);
        rst = 1'b0;
        rxd = 1'b1;
        #1;
        check("mid_reset_txd", txd, 1);
        check("mid_reset_drive", drive, 0);
        repeat (5) @(negedge sys_clk);
        rst = 1'b1;
        b_cv = n_cv; b_fe = n_fe; b_he = n_he;
        repeat (300) @(negedge sys_clk);
        check("post_reset_no_pulses", (n_cv - b_cv) + (n_fe - b_fe) + (n_he - b_he), 0);
        check("post_reset_txd", txd, 1);
        det   = 4'b1000;
        b_cv  = n_cv;
        b_rep = replies.size();
        send_byte(8'h82, 1'b1);
        repeat (200) @(negedge sys_clk);
        check("post_reset_cmd_valid", n_cv - b_cv, 1);
        check("post_reset_drive", drive, 6'b000010);
        check("post_reset_reply_count", replies.size() - b_rep, 1);
        if (replies.size() > b_rep)
            check("post_reset_reply_byte", replies[b_rep], 8'h08);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
